// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: switch/button inputs and LED/status outputs of the
// LED pattern engine, bundled so the board top and the bench share one handle.
//   i_sw      [0] run enable, [2:1] rate select, [3] direction (1 = toward LSB)
//   i_btn     [0] next mode, [1] red, [2] green, [3] blue (synchronised levels)
//   o_led     raw pattern
//   o_led_r/g/b  pattern gated by the selected colour
//   o_status  {color_sel[2:0], mode[1:0]}
interface led_pattern_ctrl_if #(
  parameter int N_LEDS = 4,
  parameter int NB_SW  = 4,
  parameter int NB_BTN = 4
);
  logic [NB_SW-1:0]  i_sw;
  logic [NB_BTN-1:0] i_btn;
  logic [N_LEDS-1:0] o_led;
  logic [N_LEDS-1:0] o_led_r;
  logic [N_LEDS-1:0] o_led_g;
  logic [N_LEDS-1:0] o_led_b;
  logic [4:0]        o_status;

  modport master (output i_sw, i_btn,
                  input  o_led, o_led_r, o_led_g, o_led_b, o_status);
  modport slave  (input  i_sw, i_btn,
                  output o_led, o_led_r, o_led_g, o_led_b, o_status);
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: LED pattern engine with rotate, flash and bounce modes.
// A switch-selected prescaler produces the step tick; button rising edges
// pick the mode and the colour bank.
//   clock    system clock (rising edge)
//   i_reset  asynchronous active-high reset
//   bus      led_pattern_ctrl_if.slave (switches, buttons, LEDs, status)
module led_pattern_ctrl #(
  parameter int N_LEDS     = 4,
  parameter int NB_COUNT   = 32,
  parameter int BASE_SHIFT = 10,
  parameter int NB_SW      = 4,
  parameter int NB_BTN     = 4
) (
  input logic               clock,
  input logic               i_reset,
  led_pattern_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_FLASH  = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_e;

  localparam logic [N_LEDS-1:0]   PAT_ONE  = N_LEDS'(1);
  localparam logic [NB_COUNT-1:0] CNT_ALL1 = '1;

  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [N_LEDS-1:0]   pat_q, pat_d;
  logic                bdir_q, bdir_d;
  mode_e               mode_q, mode_d;
  logic [2:0]          color_q, color_d;
  logic [NB_BTN-1:0]   btn_last_q, btn_last_d;

  logic [NB_BTN-1:0]   btn_rise;
  logic [1:0]          rate_k;
  logic [NB_COUNT-1:0] limit;
  logic                run_en, dir_lsb, tick, mode_chg;

  assign btn_rise = bus.i_btn & ~btn_last_q;
  assign run_en   = bus.i_sw[0];
  assign rate_k   = bus.i_sw[2:1];
  assign dir_lsb  = bus.i_sw[3];
  assign mode_chg = btn_rise[0];
  // R_k = 2^(NB_COUNT-BASE_SHIFT+k)-1 is an all-ones word shifted down.
  assign limit    = CNT_ALL1 >> (BASE_SHIFT - int'(rate_k));
  // >= rather than == so a lowered rate wraps at once instead of overrunning.
  assign tick     = run_en && (cnt_q >= limit);

  always_comb begin
    btn_last_d = bus.i_btn;

    mode_d = mode_q;
    if (btn_rise[0]) begin
      case (mode_q)
        MODE_SHIFT: mode_d = MODE_FLASH;
        MODE_FLASH: mode_d = MODE_BOUNCE;
        default:    mode_d = MODE_SHIFT;
      endcase
    end

    color_d = color_q;
    if      (btn_rise[1]) color_d = 3'b001;
    else if (btn_rise[2]) color_d = 3'b010;
    else if (btn_rise[3]) color_d = 3'b100;

    cnt_d = cnt_q;
    if (mode_chg)    cnt_d = '0;
    else if (tick)   cnt_d = '0;
    else if (run_en) cnt_d = cnt_q + NB_COUNT'(1);

    pat_d  = pat_q;
    bdir_d = bdir_q;
    if (mode_chg) begin
      // A tick coinciding with a mode change is dropped.
      pat_d  = (mode_d == MODE_FLASH) ? '0 : PAT_ONE;
      bdir_d = 1'b0;
    end else if (tick) begin
      case (mode_q)
        MODE_SHIFT: pat_d = dir_lsb ? {pat_q[0], pat_q[N_LEDS-1:1]}
                                    : {pat_q[N_LEDS-2:0], pat_q[N_LEDS-1]};
        MODE_FLASH: pat_d = ~pat_q;
        default: begin
          // Turn around on the step that leaves an end, so ends never repeat.
          if (!bdir_q) begin
            if (pat_q[N_LEDS-1]) begin bdir_d = 1'b1; pat_d = pat_q >> 1; end
            else                 pat_d = pat_q << 1;
          end else begin
            if (pat_q[0]) begin bdir_d = 1'b0; pat_d = pat_q << 1; end
            else          pat_d = pat_q >> 1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q      <= '0;
      pat_q      <= PAT_ONE;
      bdir_q     <= 1'b0;
      mode_q     <= MODE_SHIFT;
      color_q    <= 3'b001;
      btn_last_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      bdir_q     <= bdir_d;
      mode_q     <= mode_d;
      color_q    <= color_d;
      btn_last_q <= btn_last_d;
    end
  end

  assign bus.o_led    = pat_q;
  assign bus.o_led_r  = color_q[0] ? pat_q : '0;
  assign bus.o_led_g  = color_q[1] ? pat_q : '0;
  assign bus.o_led_b  = color_q[2] ? pat_q : '0;
  assign bus.o_status = {color_q, 2'(mode_q)};

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a short prescaler (R0=3 .. R3=31).
module tb_led_pattern_ctrl;
  logic clock;
  logic i_reset;
  int   n_chk;
  int   n_bad;

  led_pattern_ctrl_if #(.N_LEDS(4), .NB_SW(4), .NB_BTN(4)) bus ();

  led_pattern_ctrl #(
    .N_LEDS(4), .NB_COUNT(12), .BASE_SHIFT(10), .NB_SW(4), .NB_BTN(4)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b);
    bus.i_btn = b;
    cyc(1);
    bus.i_btn = 4'b0000;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_led"},    32'(bus.o_led),    32'h1);
    chk({tag, "_r"},      32'(bus.o_led_r),  32'h1);
    chk({tag, "_g"},      32'(bus.o_led_g),  32'h0);
    chk({tag, "_b"},      32'(bus.o_led_b),  32'h0);
    chk({tag, "_status"}, 32'(bus.o_status), 32'b00100);
  endtask

  logic [3:0] bseq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                           4'b0010, 4'b0001, 4'b0010};

  initial begin
    n_chk = 0;
    n_bad = 0;
    i_reset = 1'b0;
    bus.i_sw  = 4'b0000;
    bus.i_btn = 4'b0000;
    #1 i_reset = 1'b1;
    #1 chk_reset_outs("rst0");

    // Rotate toward MSB at k=0: first step after 4 edges, then every 4.
    @(posedge clock); #1;
    i_reset = 1'b0;
    bus.i_sw = 4'b0001;
    cyc(3); chk("rot_hold", 32'(bus.o_led), 32'h1);
    cyc(1); chk("rot1", 32'(bus.o_led), 32'h2);
    cyc(4); chk("rot2", 32'(bus.o_led), 32'h4);
    cyc(4); chk("rot3", 32'(bus.o_led), 32'h8);
    cyc(4); chk("rot_wrap", 32'(bus.o_led), 32'h1);

    // Toward LSB at k=1: 8-cycle period, LSB wraps to MSB.
    bus.i_sw = 4'b1011;
    cyc(7); chk("lsb_hold", 32'(bus.o_led), 32'h1);
    cyc(1); chk("lsb_wrap", 32'(bus.o_led), 32'h8);
    cyc(8); chk("lsb2", 32'(bus.o_led), 32'h4);

    // Reset mid-run takes effect without a clock edge.
    cyc(3);
    i_reset = 1'b1;
    #1 chk_reset_outs("rst_mid");
    @(posedge clock); #1;
    i_reset = 1'b0;

    // k=3 up to count 20, then drop to k=0: wrap on the very next edge.
    bus.i_sw = 4'b0111;
    cyc(20); chk("k3_hold", 32'(bus.o_led), 32'h1);
    bus.i_sw = 4'b0001;
    cyc(1); chk("k_drop", 32'(bus.o_led), 32'h2);
    cyc(3); chk("k_drop_hold", 32'(bus.o_led), 32'h2);
    cyc(1); chk("k_drop_next", 32'(bus.o_led), 32'h4);

    // Enable hold: freeze at count 2, resume with 2 edges left.
    cyc(2);
    bus.i_sw = 4'b0000;
    cyc(50); chk("en_frozen", 32'(bus.o_led), 32'h4);
    bus.i_sw = 4'b0001;
    cyc(1); chk("en_resume0", 32'(bus.o_led), 32'h4);
    cyc(1); chk("en_resume1", 32'(bus.o_led), 32'h8);

    // Mode cycling into FLASH.
    pulse(4'b0001);
    chk("flash_mode", 32'(bus.o_status[1:0]), 32'h1);
    chk("flash_init", 32'(bus.o_led), 32'h0);
    cyc(3); chk("flash_hold", 32'(bus.o_led), 32'h0);
    cyc(1); chk("flash_on", 32'(bus.o_led), 32'hf);
    cyc(4); chk("flash_off", 32'(bus.o_led), 32'h0);

    // BOUNCE, direction switch set but ignored.
    pulse(4'b0001);
    chk("bnc_mode", 32'(bus.o_status[1:0]), 32'h2);
    chk("bnc_init", 32'(bus.o_led), 32'h1);
    bus.i_sw = 4'b1001;
    for (int i = 0; i < 7; i++) begin
      cyc(4);
      chk($sformatf("bnc%0d", i), 32'(bus.o_led), 32'(bseq[i]));
    end

    // Third pulse back to SHIFT.
    bus.i_sw = 4'b0000;
    pulse(4'b0001);
    chk("shift_mode", 32'(bus.o_status[1:0]), 32'h0);
    chk("shift_init", 32'(bus.o_led), 32'h1);
    cyc(1);

    // Holding btn[0] advances the mode once.
    bus.i_btn = 4'b0001;
    cyc(10);
    chk("hold_once", 32'(bus.o_status[1:0]), 32'h1);
    bus.i_btn = 4'b0000;
    cyc(1);

    // Into BOUNCE (pat=0001, frozen), then colour priority G over B.
    pulse(4'b0001);
    chk("bnc2_mode", 32'(bus.o_status[1:0]), 32'h2);
    pulse(4'b1100);
    chk("col_gb", 32'(bus.o_status[4:2]), 32'b010);
    chk("col_g_led", 32'(bus.o_led_g), 32'h1);
    chk("col_r_off", 32'(bus.o_led_r), 32'h0);
    chk("col_b_off", 32'(bus.o_led_b), 32'h0);

    // Red and mode edge together: both apply.
    pulse(4'b0011);
    chk("col_r_mode", 32'(bus.o_status), 32'b00100);
    chk("col_r_led", 32'(bus.o_led_r), 32'h1);
    chk("col_g_off", 32'(bus.o_led_g), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Parametrised LED pattern generator for the board top level. It drives an N-wide LED bar and an RGB LED bank in one of three patterns: rotate, flash and bounce (ping-pong). Pattern speed comes from a switch-selected prescaler. Push-button edges select the pattern mode and the output colour. It replaces the fixed shift-register/flash pair with a single pattern engine that has a bounce mode, a selectable rate base and a status output.

## Interface
Parameters:
- N_LEDS, 4, pattern width; must be ≥ 2
- NB_COUNT, 32, prescaler counter width
- BASE_SHIFT, 10, rate base; limit R_k = 2^(NB_COUNT-BASE_SHIFT+k) - 1 for k = 0..3; requires NB_COUNT-BASE_SHIFT+3 ≤ NB_COUNT
- NB_SW, 4, switch width (fixed map below)
- NB_BTN, 4, button width (fixed map below)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_sw  in  NB_SW  [0] run enable, [2:1] rate select k, [3] direction (0 = toward MSB, 1 = toward LSB)
- i_btn  in  NB_BTN  [0] next mode, [1] red, [2] green, [3] blue; level inputs, already synchronised
- o_led  out  N_LEDS  raw pattern
- o_led_r / o_led_g / o_led_b  out  N_LEDS each  pattern gated by colour select
- o_status  out  5  {color_sel[2:0] (B,G,R one-hot), mode[1:0]}

## Operation
- Button edges: btn_last is registered from i_btn and resets to 0. A rising edge is i_btn & ~btn_last. A button held through reset release therefore registers one edge on the first clock.
- Mode register:
  - Encodings: SHIFT = 2'd0, FLASH = 2'd1, BOUNCE = 2'd2. 2'd3 is never reachable.
  - Reset value is SHIFT.
  - Each edge on btn[0] advances SHIFT → FLASH → BOUNCE → SHIFT.
- Colour register:
  - Reset value is R = 3'b001.
  - Edges on btn[1], btn[2], btn[3] select R, G, B respectively (001, 010, 100).
  - Simultaneous edges resolve by priority btn[1] > btn[2] > btn[3].
  - A mode edge and a colour edge in the same cycle both take effect.
- Prescaler:
  - limit = R_k with k = i_sw[2:1], evaluated combinationally every cycle.
  - With i_sw[0]=1: if counter ≥ limit, counter ← 0 and tick=1 that cycle; otherwise counter ← counter+1.
  - With i_sw[0]=0: counter holds and tick=0.
  - The ≥ comparison means that lowering the rate mid-count wraps on the next enabled cycle, with no overrun.
- Pattern register (pat, N_LEDS bits) and bounce direction flag bdir (0 = up):
  - On a mode change: pat is reinitialised to 0…01 for SHIFT and BOUNCE, or all-zero for FLASH. bdir ← 0 and counter ← 0. A tick in the same cycle is ignored.
  - SHIFT on tick: rotate by 1. Direction is toward MSB if i_sw[3]=0, toward LSB if i_sw[3]=1. The MSB wraps to the LSB and vice versa.
  - FLASH on tick: pat ← ~pat.
  - BOUNCE on tick (i_sw[3] ignored):
    - While moving up, pat shifts toward MSB. On reaching bit N_LEDS-1, the next tick sets bdir=1 and moves to bit N_LEDS-2.
    - The same rule applies symmetrically at bit 0.
    - The sequence has no repeated endpoint: 1,2,4,8,4,2,1,2… for N_LEDS=4.
- Outputs: o_led = pat. o_led_c = pat when color_sel bit c = 1, else 0. o_status = {color_sel, mode}.

## Timing
- Reset (async, while i_reset=1): counter=0, pat=0…01, bdir=0, mode=SHIFT, color_sel=001, btn_last=0. Output values during reset:
  - o_led = 0…01
  - o_led_r = 0…01
  - o_led_g = 0
  - o_led_b = 0
  - o_status = 5'b00100
- Reset asserted mid-pattern returns every register to its reset value immediately, without waiting for a clock.
- Button edge in cycle t → mode/colour updated at t+1 → outputs change at t+1 (all outputs come combinationally from registers).
- Tick period = R_k + 1 cycles while enabled. pat updates on the clock edge at the end of the tick cycle.
- Toggling i_sw[0] off and then on resumes the count from the held value; no tick is lost or duplicated.

## Test plan
Bench parameters: NB_COUNT=12, BASE_SHIFT=10, so R0=3, R1=7, R2=15, R3=31.
- Reset values: assert i_reset mid-run → o_led=4'b0001, o_led_r=4'b0001, o_led_g=0, o_led_b=0, o_status=5'b00100 immediately. After release with i_sw=4'b0001, o_led steps 0001→0010→0100→1000→0001 every 4 cycles.
- Direction and rate: i_sw=4'b1011 (k=1, toward LSB) → o_led steps 0001→1000→0100 every 8 cycles. Switch k from 3 to 0 while counter=20 → tick on the next cycle, then every 4 cycles.
- Mode cycling: one btn[0] pulse → o_status[1:0]=01 and o_led=0000 the next cycle, then 1111/0000 alternation per tick. A second pulse → 10 with o_led=0001; a third → 00. Holding btn[0] for 10 cycles advances the mode only once.
- Bounce: BOUNCE, k=0 → o_led sequence 0001,0010,0100,1000,0100,0010,0001,0010 at 4-cycle spacing; i_sw[3] has no effect.
- Colour priority: pulse btn[2] and btn[3] in the same cycle → o_status[4:2]=010, o_led_g=o_led, o_led_r=o_led_b=0. Pulse btn[1] and btn[0] together → colour=001 and mode advances in the same cycle.
- Enable hold: clear i_sw[0] for 50 cycles → o_led is frozen and the counter holds. Re-enable → the next step arrives after the remaining count, not a full period.
